// File: rtl/sim_multiport_dram.sv
// Multi-port simulation DRAM. NUM_PORTS request channels share one
// word-addressed array through a round-robin arbiter that admits at most one
// request per cycle. Reads travel a fixed READ_LATENCY pipeline and land in a
// per-port response FIFO. Each port's reads are admitted only while the port's
// credit (FIFO occupancy + reads in flight) is below the FIFO depth. That
// guarantees a pipeline push always finds room.
//
// Handshake: a request on port p transfers on the rising edge that ends a
// cycle in which mem_req_valid[p] & mem_req_grant_out[p] are both high.
// grant_out is combinational, and valid may be dropped or changed freely
// before a grant. A response on port p pops on the rising edge that ends a
// cycle in which mem_resp_valid[p] & mem_resp_grant_in[p] are both high.
// grant_in with an empty FIFO has no effect.
module sim_multiport_dram #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int LOG_SIZE     = 10,
  parameter int LOG_Q_SIZE   = 4,
  parameter int READ_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            mem_req_valid,
  input  logic [NUM_PORTS-1:0]            mem_req_is_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_req_data,
  output logic [NUM_PORTS-1:0]            mem_req_grant_out,
  output logic [NUM_PORTS-1:0]            mem_resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_resp_data,
  input  logic [NUM_PORTS-1:0]            mem_resp_grant_in
);

  localparam int DEPTH  = 1 << LOG_SIZE;
  localparam int QDEPTH = 1 << LOG_Q_SIZE;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW     = LOG_Q_SIZE + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

  // Arbitration state and per-port credit bookkeeping
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         inflight_q [NUM_PORTS];
  logic [CW-1:0]         inflight_d [NUM_PORTS];
  logic [CW-1:0]         fifo_cnt_q [NUM_PORTS];
  logic [CW-1:0]         fifo_cnt_d [NUM_PORTS];
  logic [LOG_Q_SIZE-1:0] wr_ptr_q   [NUM_PORTS];
  logic [LOG_Q_SIZE-1:0] wr_ptr_d   [NUM_PORTS];
  logic [LOG_Q_SIZE-1:0] rd_ptr_q   [NUM_PORTS];
  logic [LOG_Q_SIZE-1:0] rd_ptr_d   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] fifo_mem_q [NUM_PORTS][QDEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [NUM_PORTS][QDEPTH];

  // Read latency pipeline: stage 0 is loaded at the accepting edge
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [PW-1:0]           pipe_port_q [READ_LATENCY];
  logic [PW-1:0]           pipe_port_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];

  // Backing store: zero from time 0, deliberately untouched by reset
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic [NUM_PORTS-1:0]  eligible;
  logic [CW-1:0]         credit [NUM_PORTS];
  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         scan_p;
  logic                  acc_read, acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [LOG_SIZE-1:0]   acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  addr_hi_unused;
  logic                  push_vld;
  logic [PW-1:0]         push_port;
  logic [DATA_WIDTH-1:0] push_data;

  // Eligibility: writes always, reads only while the port has credit left
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      credit[p]   = fifo_cnt_q[p] + inflight_q[p];
      eligible[p] = rst & mem_req_valid[p] &
                    (mem_req_is_write[p] | (credit[p] < Q_FULL));
    end
  end

  // Round-robin pick: first eligible port at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_p    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_p = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!win_found && eligible[scan_p]) begin
        win_found = 1'b1;
        win_idx   = scan_p;
      end
    end
    mem_req_grant_out = '0;
    if (win_found) mem_req_grant_out[win_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (win_found) rr_ptr_d = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
  end

  // Decode the winning request into array access controls
  always_comb begin
    acc_addr  = mem_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    acc_wdata = mem_req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    acc_idx   = acc_addr[LOG_SIZE-1:0];
    acc_write = win_found & mem_req_is_write[win_idx];
    acc_read  = win_found & ~mem_req_is_write[win_idx];
  end

  // Address bits above the array index alias onto the same words
  assign addr_hi_unused = ^acc_addr[ADDR_WIDTH-1:LOG_SIZE];

  // Array write port
  always_ff @(posedge clk) begin
    if (acc_write) mem_q[acc_idx] <= acc_wdata;
  end

  // Pipeline advance: new read enters stage 0, the rest shift by one
  always_comb begin
    pipe_vld_d[0]  = acc_read;
    pipe_port_d[0] = win_idx;
    pipe_data_d[0] = mem_q[acc_idx];
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_port_d[s] = pipe_port_q[s-1];
      pipe_data_d[s] = pipe_data_q[s-1];
    end
    push_vld  = pipe_vld_q[READ_LATENCY-1];
    push_port = pipe_port_q[READ_LATENCY-1];
    push_data = pipe_data_q[READ_LATENCY-1];
  end

  // FIFO push/pop and in-flight accounting per port
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic do_push, do_pop, do_inc;
      do_push       = push_vld && (push_port == PW'(p));
      do_pop        = mem_resp_valid[p] & mem_resp_grant_in[p];
      do_inc        = acc_read && (win_idx == PW'(p));
      wr_ptr_d[p]   = wr_ptr_q[p];
      rd_ptr_d[p]   = rd_ptr_q[p];
      if (do_push) begin
        fifo_mem_d[p][wr_ptr_q[p]] = push_data;
        wr_ptr_d[p] = wr_ptr_q[p] + 1'b1;
      end
      if (do_pop) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      fifo_cnt_d[p] = fifo_cnt_q[p] + CW'(do_push) - CW'(do_pop);
      inflight_d[p] = inflight_q[p] + CW'(do_inc) - CW'(do_push);
    end
  end

  // Response outputs: head of each FIFO, zero when empty
  always_comb begin
    mem_resp_valid = '0;
    mem_resp_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      mem_resp_valid[p] = (fifo_cnt_q[p] != '0);
      if (mem_resp_valid[p])
        mem_resp_data[p*DATA_WIDTH +: DATA_WIDTH] = fifo_mem_q[p][rd_ptr_q[p]];
    end
  end

  // Control state: cleared by reset, which discards reads in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      pipe_vld_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        inflight_q[p] <= '0;
        fifo_cnt_q[p] <= '0;
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        inflight_q[p] <= inflight_d[p];
        fifo_cnt_q[p] <= fifo_cnt_d[p];
        wr_ptr_q[p]   <= wr_ptr_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
      end
    end
  end

  // Data-path storage: qualified by the valids above, so no reset needed
  always_ff @(posedge clk) begin
    pipe_port_q <= pipe_port_d;
    pipe_data_q <= pipe_data_d;
    fifo_mem_q  <= fifo_mem_d;
  end

endmodule

// File: tb/tb_sim_multiport_dram.sv
// Bench for sim_multiport_dram: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the memory.
module tb_sim_multiport_dram;

  localparam int NP  = 2;
  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int LAT = 4;
  localparam int QD  = 16;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_is_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_data;
  logic [NP-1:0]     grant_out;
  logic [NP-1:0]     resp_valid;
  logic [NP*DW-1:0]  resp_data;
  logic [NP-1:0]     resp_grant_in;

  sim_multiport_dram #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LOG_SIZE(10), .LOG_Q_SIZE(4), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(req_valid), .mem_req_is_write(req_is_write),
    .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_grant_out(grant_out), .mem_resp_valid(resp_valid),
    .mem_resp_data(resp_data), .mem_resp_grant_in(resp_grant_in)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int          port;
    int          due;
    logic [DW-1:0] data;
  } pend_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl_mem [1024];
  logic [DW-1:0] exp_q [NP][$];
  pend_t         pend_q[$];
  int            m_rr = 0;

  logic [DW-1:0] pop_log [NP][$];
  int            grant_seq[$];
  bit            arm_timing = 0;
  int            first_rd_grant_edge = -1;
  int            first_valid_edge = -1;

  initial for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int credit_of(input int p);
    int c;
    c = exp_q[p].size();
    foreach (pend_q[i]) if (pend_q[i].port == p) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] log_at(input int p, input int i);
    if (i < pop_log[p].size()) return pop_log[p][i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Compare every output against the model, then advance the model by one edge
  always @(negedge clk) begin : monitor
    int            win;
    int            p;
    logic [NP-1:0] m_grant;
    logic [AW-1:0] a;
    if (!rst) begin
      chk("rst_grant", grant_out, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_data", resp_data, 0);
      for (int q = 0; q < NP; q++) exp_q[q].delete();
      pend_q.delete();
      m_rr = 0;
    end else begin
      win = -1;
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (win < 0 && req_valid[p] && (req_is_write[p] || credit_of(p) < QD)) win = p;
      end
      m_grant = '0;
      if (win >= 0) m_grant[win] = 1'b1;
      chk("grant", grant_out, m_grant);
      for (int q = 0; q < NP; q++) begin
        chk($sformatf("resp_valid%0d", q), resp_valid[q], exp_q[q].size() > 0);
        chk($sformatf("resp_data%0d", q), resp_data[q*DW +: DW],
            (exp_q[q].size() > 0) ? exp_q[q][0] : '0);
      end
      // observation logs built from what the DUT actually did
      for (int q = 0; q < NP; q++)
        if (resp_valid[q] && resp_grant_in[q]) pop_log[q].push_back(resp_data[q*DW +: DW]);
      for (int q = 0; q < NP; q++) if (grant_out[q]) grant_seq.push_back(q);
      if (arm_timing && first_rd_grant_edge < 0 && grant_out[0] && !req_is_write[0])
        first_rd_grant_edge = edge_n;
      if (arm_timing && first_valid_edge < 0 && resp_valid[0])
        first_valid_edge = edge_n;
      // model step for the coming edge
      for (int q = 0; q < NP; q++)
        if (exp_q[q].size() > 0 && resp_grant_in[q]) void'(exp_q[q].pop_front());
      while (pend_q.size() > 0 && pend_q[0].due == edge_n + 1) begin
        exp_q[pend_q[0].port].push_back(pend_q[0].data);
        if (exp_q[pend_q[0].port].size() > QD) begin
          $display("FAIL fifo_overflow actual=%0d required<=%0d", exp_q[pend_q[0].port].size(), QD);
          errors++;
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "overflow");
        end
        void'(pend_q.pop_front());
      end
      if (win >= 0) begin
        a = req_addr[win*AW +: AW];
        if (req_is_write[win]) mdl_mem[a[9:0]] = req_data[win*DW +: DW];
        else pend_q.push_back('{port: win, due: edge_n + 1 + LAT, data: mdl_mem[a[9:0]]});
        m_rr = (win + 1) % NP;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_is_write[p]    = wr;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold one request until granted (bounded), then drop it
  task automatic req_wait(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    int t;
    set_req(p, wr, a, d);
    req_valid[p] = 1'b1;
    got = 0;
    t = 0;
    while (!got && t < 100) begin
      @(negedge clk);
      got = grant_out[p];
      @(posedge clk);
      #1;
      t++;
    end
    req_valid[p] = 1'b0;
    chk("req_granted", got, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] c0 [4];
  logic [DW-1:0] c1 [4];

  initial begin
    int n;
    int cnt [NP];
    int g;
    rst = 1'b0;
    req_valid = '0;
    req_is_write = '0;
    req_addr = '0;
    req_data = '0;
    resp_grant_in = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single port: writes then reads, latency check
    req_wait(0, 1, 0, 1);
    req_wait(0, 1, 1, 3);
    req_wait(0, 1, 2, 5);
    req_wait(0, 1, 3, 7);
    pop_log[0].delete();
    arm_timing = 1;
    for (int i = 0; i < 4; i++) req_wait(0, 0, i, 0);
    idle(12);
    arm_timing = 0;
    chk("t1_count", pop_log[0].size(), 4);
    chk("t1_d0", log_at(0, 0), 1);
    chk("t1_d1", log_at(0, 1), 3);
    chk("t1_d2", log_at(0, 2), 5);
    chk("t1_d3", log_at(0, 3), 7);
    chk("t1_latency", first_valid_edge - first_rd_grant_edge, LAT + 1);

    // contention: both ports read continuously for 8 cycles
    for (int i = 0; i < 4; i++) begin
      c0[i] = {$urandom, $urandom};
      c1[i] = {$urandom, $urandom};
      req_wait(0, 1, 16 + i, c0[i]);
    end
    for (int i = 0; i < 4; i++) req_wait(1, 1, 32 + i, c1[i]);
    pop_log[0].delete();
    pop_log[1].delete();
    grant_seq.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 0, 16 + cnt[0], 0);
      set_req(1, 0, 32 + cnt[1], 0);
      req_valid = 2'b11;
      @(negedge clk);
      if (grant_out[0]) cnt[0]++;
      if (grant_out[1]) cnt[1]++;
      @(posedge clk);
      #1;
    end
    idle(12);
    chk("t2_grants", grant_seq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_order%0d", i), (i < grant_seq.size()) ? grant_seq[i] : -1, i % 2);
    chk("t2_cnt0", pop_log[0].size(), 4);
    chk("t2_cnt1", pop_log[1].size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_p0_%0d", i), log_at(0, i), c0[i]);
      chk($sformatf("t2_p1_%0d", i), log_at(1, i), c1[i]);
    end

    // backpressure: 20 reads into a 16-deep FIFO with no consumer
    resp_grant_in = 2'b10;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      set_req(0, 0, 100 + n, 0);
      req_valid[0] = (n < 20);
      @(negedge clk);
      if (grant_out[0]) n++;
      @(posedge clk);
      #1;
    end
    chk("t3_grants16", n, 16);
    for (int k = 0; k < 4; k++) begin
      g = 0;
      resp_grant_in[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        set_req(0, 0, 100 + n, 0);
        req_valid[0] = (n < 20);
        @(negedge clk);
        if (grant_out[0]) begin
          n++;
          g++;
        end
        @(posedge clk);
        #1;
        resp_grant_in[0] = 1'b0;
      end
      chk($sformatf("t3_pop_grant%0d", k), g, 1);
    end
    req_valid = '0;
    resp_grant_in = 2'b11;
    idle(30);

    // write on port 1 then read on port 0 the very next cycle
    pop_log[0].delete();
    set_req(1, 1, 5, 64'hAA);
    req_valid = 2'b10;
    @(negedge clk);
    chk("t4_wgrant", grant_out, 2'b10);
    @(posedge clk);
    #1;
    set_req(0, 0, 5, 0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t4_rgrant", grant_out, 2'b01);
    @(posedge clk);
    #1;
    idle(10);
    chk("t4_data", log_at(0, 0), 64'hAA);

    // reset with 2 FIFO entries and 3 reads in flight
    resp_grant_in = 2'b10;
    req_wait(0, 0, 0, 0);
    req_wait(0, 0, 1, 0);
    idle(8);
    req_wait(0, 0, 2, 0);
    req_wait(0, 0, 3, 0);
    req_wait(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid_now", resp_valid, 0);
    chk("t5_data_now", resp_data, 0);
    chk("t5_grant_now", grant_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    resp_grant_in = 2'b11;
    pop_log[0].delete();
    idle(12);
    chk("t5_no_stale", pop_log[0].size(), 0);
    req_wait(0, 0, 3, 0);
    req_wait(0, 1, 2, 64'h1234);
    req_wait(0, 0, 2, 0);
    idle(10);
    chk("t5_count", pop_log[0].size(), 2);
    chk("t5_kept", log_at(0, 0), 7);
    chk("t5_new", log_at(0, 1), 64'h1234);

    // aliasing: upper address bits are ignored
    pop_log[1].delete();
    req_wait(0, 1, 1024 + 7, 64'h55);
    req_wait(1, 0, 7, 0);
    idle(10);
    chk("t6_alias", log_at(1, 0), 64'h55);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      for (int q = 0; q < NP; q++)
        set_req(q, $urandom_range(0, 2) == 0,
                {32'($urandom), 32'($urandom_range(0, 31))}, {$urandom, $urandom});
      req_valid = NP'($urandom);
      resp_grant_in = (i % 100 < 40) ? NP'($urandom & $urandom) : NP'($urandom | $urandom);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    resp_grant_in = 2'b11;
    idle(40);
    chk("drain_p0", exp_q[0].size(), 0);
    chk("drain_p1", exp_q[1].size(), 0);
    chk("drain_pend", pend_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_multiport_dram.md
Name: sim_multiport_dram

Overview:
- Parametrised simulation DRAM model that serves NUM_PORTS independent request/response channels from one shared word-addressed array.
- Round-robin arbitration admits at most one request per cycle. Reads return after a fixed, configurable latency into per-port response FIFOs, in request order per port.
- Used as the memory back-end in block-level benches and in full-system simulation in place of the single-port simple DRAM model.

Parameters:
- NUM_PORTS, 2, number of request/response channels (1..8)
- DATA_WIDTH, 64, data word width in bits
- ADDR_WIDTH, 64, request address width per port
- LOG_SIZE, 10, log2 of array depth in words
- LOG_Q_SIZE, 4, log2 of per-port response FIFO depth
- READ_LATENCY, 4, cycles from read acceptance to FIFO push (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req_valid  in  NUM_PORTS  per-port request valid
- mem_req_is_write  in  NUM_PORTS  1 = write, 0 = read
- mem_req_addr  in  NUM_PORTS*ADDR_WIDTH  word address, port p at slice p
- mem_req_data  in  NUM_PORTS*DATA_WIDTH  write data
- mem_req_grant_out  out  NUM_PORTS  request accepted this cycle (combinational)
- mem_resp_valid  out  NUM_PORTS  response FIFO non-empty
- mem_resp_data  out  NUM_PORTS*DATA_WIDTH  head-of-FIFO read data
- mem_resp_grant_in  in  NUM_PORTS  consumer pops head this cycle

Behaviour:
- Array index = addr[LOG_SIZE-1:0]; upper address bits are ignored. The array is zero at time 0 and is not cleared by reset.
- Eligibility of port p:
  - Writes: mem_req_valid[p]=1.
  - Reads: mem_req_valid[p]=1 and credit[p] < 2^LOG_Q_SIZE, where credit = FIFO occupancy + in-flight reads for p.
- Arbitration: among eligible ports, the first at or after rr_ptr (wrapping) wins. grant_out is one-hot or zero, is combinational from the valids, and the transfer happens on the next rising edge.
- rr_ptr update: on a grant, rr_ptr <= winner+1 mod NUM_PORTS. It is unchanged when no grant is issued.
- Write accepted: the array word is updated at the edge. No response is generated.
- Read accepted:
  - Array data is captured at the edge into stage 1 of a READ_LATENCY-deep valid/port-id/data pipeline.
  - At the last stage, the entry is pushed into FIFO[port-id] and that port's in-flight count decrements.
  - Read data reflects all writes accepted in earlier cycles.
- Responses:
  - mem_resp_valid[p] = FIFO[p] non-empty.
  - Pop happens when mem_resp_valid[p] & mem_resp_grant_in[p].
  - grant_in with the FIFO empty is ignored.
- Push and pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
- The credit scheme guarantees a pipeline push never finds the FIFO full. The bench asserts this; overflow is a fatal error.
- Per-port responses arrive in acceptance order. There is no ordering across ports.
- Reset (rst=0, asynchronous):
  - mem_req_grant_out=0, mem_resp_valid=0, mem_resp_data=0.
  - Pipeline valids cleared, FIFOs emptied, in-flight counts 0, rr_ptr=0.
  - In-flight reads are discarded.
- Release: grants may assert in the first cycle after rst rises.
- Widths: in-flight/credit counters are LOG_Q_SIZE+1 bits. rr_ptr is $clog2(NUM_PORTS) bits, minimum 1.

Test Plan:
- Single port, defaults:
  - Stimulus: writes addr 0..3 with data 1,3,5,7, then reads addr 0..3 with grant_in held 1.
  - Required: mem_resp_data sequence 1,3,5,7. First mem_resp_valid exactly READ_LATENCY+1 edges after the first read grant.
- Contention:
  - Stimulus: both ports hold valid reads continuously for 8 cycles.
  - Required: grants alternate 0,1,0,1… and each port receives 4 responses in its own address order.
- Backpressure:
  - Stimulus: port 0 issues 20 reads with grant_in=0, LOG_Q_SIZE=4.
  - Required: exactly 16 grants, then grant_out[0]=0 until a pop, then one grant per pop. No overflow.
- Write-then-read adjacency:
  - Stimulus: port 1 writes 0xAA to addr 5 in cycle n; port 0 reads addr 5 in cycle n+1.
  - Required: port 0 returns 0xAA.
- Reset mid-operation:
  - Stimulus: rst low with 3 reads in flight and 2 FIFO entries.
  - Required: all valids 0 immediately. After release, no stale responses; a new read returns the current array value.
- Wrap/aliasing:
  - Stimulus: write 0x55 to addr 1024+7, read addr 7 (LOG_SIZE=10).
  - Required: returns 0x55.
